// File: rtl/bitnet_pkg.sv
// Shared definitions for the bitnet datapath.
//   LFSR_W / LFSR_IW / LFSR_TAPS : 16-bit Galois LFSR geometry (taps 16,14,13,11)
//   fc_state_t                   : fc_seq controller states
//   popcount()                   : ones count of a zero-extended vector
//   lfsr_step()                  : one LFSR advance with entropy injection
package bitnet_pkg;

  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned LFSR_IW   = 4;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned POP_MAXW  = 256;

  typedef enum logic [1:0] {
    FC_IDLE,
    FC_FWD,
    FC_BWD,
    FC_DONE
  } fc_state_t;

  // Callers zero-extend their operand to POP_MAXW bits.
  function automatic int unsigned popcount(input logic [POP_MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAXW; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  // Right-shifting Galois step; entropy enters at bit 0 and the all-zero
  // lock-up state is escaped by reloading the seed.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                  input logic              ent,
                                                  input logic [LFSR_W-1:0] seed);
    logic [LFSR_W-1:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end
    n[0] = n[0] ^ ent;
    if (n == '0) begin
      n = seed;
    end
    return n;
  endfunction

endpackage

// File: rtl/fc_lane.sv
// Combinational per-row logic of the binary fully-connected layer.
//   w_row_i  : current weight row W[j]
//   fin_i    : input activations
//   bin_i    : error bit for this output neuron
//   rnd_i    : per-bit flip enable from the LFSR
//   maj_o    : XNOR-majority output (ties resolve to 1)
//   agree_o  : bits where the row agreed with the input on a wrong output
//   w_next_o : row after stochastic flips
module fc_lane
  import bitnet_pkg::*;
#(
  parameter int unsigned N_IN = 16
) (
  input  logic [N_IN-1:0] w_row_i,
  input  logic [N_IN-1:0] fin_i,
  input  logic            bin_i,
  input  logic [N_IN-1:0] rnd_i,
  output logic            maj_o,
  output logic [N_IN-1:0] agree_o,
  output logic [N_IN-1:0] w_next_o
);

  logic [N_IN-1:0] match;

  always_comb begin
    match    = ~(fin_i ^ w_row_i);
    maj_o    = popcount(POP_MAXW'(match)) >= (N_IN + 1) / 2;
    agree_o  = {N_IN{bin_i}} & match;
    w_next_o = w_row_i ^ (agree_o & rnd_i);
  end

endmodule

// File: rtl/fc_seq.sv
// Time-multiplexed binary fully-connected layer, LANES neurons per cycle.
//   clk_in, rst_in    : clock, synchronous active-high reset
//   oscillator        : asynchronous entropy bit (2-flop synchronised)
//   fd_prop / bk_prop : start forward / backward pass (sampled in IDLE)
//   fin, bin          : activations and per-neuron error bits, held while busy
//   fout, bout        : forward result / backward blame registers
//   busy, done        : pass in progress / one-cycle completion pulse
//   rd_row            : debug row index, control_out = W[rd_row]
module fc_seq
  import bitnet_pkg::*;
#(
  parameter int unsigned       N_IN       = 16,
  parameter int unsigned       N_OUT      = 16,
  parameter int unsigned       LANES      = 4,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter int unsigned       FLIP_SHIFT = 2,
  localparam int unsigned      RW         = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int unsigned      CW         = $clog2(N_OUT + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             oscillator,
  input  logic             fd_prop,
  input  logic             bk_prop,
  input  logic [N_IN-1:0]  fin,
  input  logic [N_OUT-1:0] bin,
  output logic [N_OUT-1:0] fout,
  output logic [N_IN-1:0]  bout,
  output logic             busy,
  output logic             done,
  input  logic [RW-1:0]    rd_row,
  output logic [N_IN-1:0]  control_out
);

  localparam logic [RW-1:0] LAST_ROW = RW'(N_OUT - LANES);
  localparam logic [RW-1:0] ROW_STEP = RW'(LANES);

  fc_state_t         state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic              bwd_mode_q, bwd_mode_d;
  logic [N_IN-1:0]   w_q [N_OUT];
  logic [CW-1:0]     cnt_q [N_IN];
  logic [CW-1:0]     cnt_d [N_IN];
  logic [N_OUT-1:0]  shadow_q, shadow_d;
  logic [N_OUT-1:0]  fout_q;
  logic [N_IN-1:0]   bout_q, bout_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              osc_meta_q, osc_sync_q;
  logic              start_bwd;
  int unsigned       pop_bin;

  logic [RW-1:0]     lane_row   [LANES];
  logic [N_IN-1:0]   lane_w     [LANES];
  logic [N_IN-1:0]   lane_rnd   [LANES];
  logic [N_IN-1:0]   lane_agree [LANES];
  logic [N_IN-1:0]   lane_wnext [LANES];
  logic [LANES-1:0]  lane_maj;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_row[l] = row_q + RW'(l);
    assign lane_w[l]   = w_q[lane_row[l]];

    fc_lane #(.N_IN(N_IN)) u_lane (
      .w_row_i  (lane_w[l]),
      .fin_i    (fin),
      .bin_i    (bin[lane_row[l]]),
      .rnd_i    (lane_rnd[l]),
      .maj_o    (lane_maj[l]),
      .agree_o  (lane_agree[l]),
      .w_next_o (lane_wnext[l])
    );
  end

  // Flip enable: AND of FLIP_SHIFT consecutive LFSR bits starting at i,
  // rotated by 3 per lane so lanes draw from different bit windows.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        lane_rnd[l][i] = 1'b1;
        for (int unsigned k = 0; k < FLIP_SHIFT; k++) begin
          lane_rnd[l][i] = lane_rnd[l][i] & lfsr_q[LFSR_IW'(i + k + 3 * l)];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    bwd_mode_d = bwd_mode_q;
    unique case (state_q)
      FC_IDLE: begin
        if (fd_prop) begin
          state_d    = FC_FWD;
          row_d      = '0;
          bwd_mode_d = 1'b0;
        end else if (bk_prop) begin
          state_d    = FC_BWD;
          row_d      = '0;
          bwd_mode_d = 1'b1;
        end
      end
      FC_FWD, FC_BWD: begin
        row_d = row_q + ROW_STEP;
        if (row_q == LAST_ROW) begin
          state_d = FC_DONE;
        end
      end
      FC_DONE: state_d = FC_IDLE;
      default: state_d = FC_IDLE;
    endcase
  end

  assign start_bwd = (state_q == FC_IDLE) && !fd_prop && bk_prop;

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (start_bwd) begin
        cnt_d[i] = '0;
      end else if (state_q == FC_BWD) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          cnt_d[i] = cnt_d[i] + CW'(lane_agree[l][i]);
        end
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (state_q == FC_FWD) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        shadow_d[lane_row[l]] = lane_maj[l];
      end
    end
  end

  // Blame needs at least one agreement and at least half of the wrong
  // neurons agreeing; bin == 0 therefore yields no blame.
  always_comb begin
    pop_bin = popcount(POP_MAXW'(bin));
    for (int unsigned i = 0; i < N_IN; i++) begin
      bout_d[i] = (cnt_q[i] != '0) && ((2 * 32'(cnt_q[i])) >= pop_bin);
    end
  end

  assign lfsr_d = lfsr_step(lfsr_q, osc_sync_q, SEED);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= FC_IDLE;
      row_q      <= '0;
      bwd_mode_q <= 1'b0;
      shadow_q   <= '0;
      fout_q     <= '0;
      bout_q     <= '0;
      lfsr_q     <= SEED;
      osc_meta_q <= 1'b0;
      osc_sync_q <= 1'b0;
      for (int unsigned r = 0; r < N_OUT; r++) begin
        w_q[r] <= '0;
      end
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      bwd_mode_q <= bwd_mode_d;
      shadow_q   <= shadow_d;
      lfsr_q     <= lfsr_d;
      osc_meta_q <= oscillator;
      osc_sync_q <= osc_meta_q;
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (state_q == FC_BWD) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          w_q[lane_row[l]] <= lane_wnext[l];
        end
      end
      if (state_q == FC_DONE) begin
        if (bwd_mode_q) begin
          bout_q <= bout_d;
        end else begin
          fout_q <= shadow_q;
        end
      end
    end
  end

  assign fout        = fout_q;
  assign bout        = bout_q;
  assign busy        = (state_q != FC_IDLE);
  assign done        = (state_q == FC_DONE);
  assign control_out = w_q[rd_row];

endmodule

// File: tb/tb_fc_seq.sv
// Directed self-checking bench for fc_seq (N_IN=9, N_OUT=8, LANES=4,
// FLIP_SHIFT=0 so weight flips are deterministic).
module tb_fc_seq;

  localparam int unsigned NI = 9;
  localparam int unsigned NO = 8;
  localparam int unsigned LN = 4;
  localparam int unsigned G  = NO / LN;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          osc = 1'b0;
  logic          osc_hold = 1'b0;
  logic          fd_prop = 1'b0;
  logic          bk_prop = 1'b0;
  logic [NI-1:0] fin = '0;
  logic [NO-1:0] bin = '0;
  logic [NO-1:0] fout;
  logic [NI-1:0] bout;
  logic          busy;
  logic          done;
  logic [2:0]    rd_row = '0;
  logic [NI-1:0] control_out;

  always #5 clk = ~clk;

  always @(negedge clk) osc = osc_hold ? 1'b0 : 1'($urandom_range(0, 1));

  fc_seq #(
    .N_IN       (NI),
    .N_OUT      (NO),
    .LANES      (LN),
    .SEED       (SEED_V),
    .FLIP_SHIFT (0)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .oscillator  (osc),
    .fd_prop     (fd_prop),
    .bk_prop     (bk_prop),
    .fin         (fin),
    .bin         (bin),
    .fout        (fout),
    .bout        (bout),
    .busy        (busy),
    .done        (done),
    .rd_row      (rd_row),
    .control_out (control_out)
  );

  typedef struct packed {
    logic [NO-1:0] fout;
    logic [NI-1:0] bout;
  } exp_t;

  exp_t          sb[$];
  logic [NI-1:0] mw [NO];
  logic [NO-1:0] mfout = '0;
  logic [NI-1:0] mbout = '0;
  int unsigned   checks = 0;
  int unsigned   passed = 0;
  int unsigned   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NO; r++) mw[r] = '0;
    mfout = '0;
    mbout = '0;
  endtask

  // Reference behaviour of one pass; forward wins when both starts are high.
  task automatic model_pass(input logic f, input logic b);
    int unsigned c [NI];
    int unsigned agree, pb;
    if (f) begin
      for (int j = 0; j < NO; j++) begin
        agree = 0;
        for (int i = 0; i < NI; i++) if (fin[i] == mw[j][i]) agree++;
        mfout[j] = (agree >= (NI + 1) / 2);
      end
    end else if (b) begin
      pb = 0;
      for (int i = 0; i < NI; i++) c[i] = 0;
      for (int j = 0; j < NO; j++) begin
        if (bin[j]) begin
          pb++;
          for (int i = 0; i < NI; i++) begin
            if (mw[j][i] == fin[i]) begin
              c[i]++;
              mw[j][i] = ~mw[j][i];
            end
          end
        end
      end
      for (int i = 0; i < NI; i++) mbout[i] = (c[i] >= 1) && (2 * c[i] >= pb);
    end
    sb.push_back('{fout: mfout, bout: mbout});
  endtask

  task automatic check_w(input string tag);
    for (int r = 0; r < NO; r++) begin
      rd_row = 3'(r);
      #1;
      chk(tag, 32'(control_out), 32'(mw[r]));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Starts a pass, follows busy/done for a fixed number of cycles and
  // compares the result registers in the first cycle after DONE.
  task automatic run_pass(input logic f, input logic b, input logic [NI-1:0] fin_v,
                          input logic [NO-1:0] bin_v, input logic mid_pulse, input string tag);
    exp_t        e;
    int unsigned done_cyc, done_cnt;
    logic        busy_ok;
    @(negedge clk);
    fin = fin_v;
    bin = bin_v;
    fd_prop = f;
    bk_prop = b;
    model_pass(f, b);
    @(negedge clk);
    fd_prop = 1'b0;
    bk_prop = 1'b0;
    done_cyc = 0;
    done_cnt = 0;
    busy_ok  = 1'b1;
    for (int c = 1; c <= G + 2; c++) begin
      fd_prop = mid_pulse && (c == 1);
      if (busy !== (c <= G + 1)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c < G + 2) @(negedge clk);
    end
    fd_prop = 1'b0;
    chk({tag, " busy window"}, 32'(busy_ok), 32'd1);
    chk({tag, " done cycle"}, done_cyc, G + 1);
    chk({tag, " done pulses"}, done_cnt, 1);
    e = sb.pop_front();
    chk({tag, " fout"}, 32'(fout), 32'(e.fout));
    chk({tag, " bout"}, 32'(bout), 32'(e.bout));
  endtask

  localparam logic [NI-1:0] PAT = 9'b101101001;

  logic        flag;

  initial begin
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset fout", 32'(fout), 32'd0);
    chk("reset bout", 32'(bout), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset lfsr", 32'(dut.lfsr_q), 32'(SEED_V));
    rst = 1'b0;
    check_w("reset W");

    // Forward on zero weights: 3 agreements out of 9, below the 5 needed.
    run_pass(1'b1, 1'b0, 9'b111000111, 8'h00, 1'b0, "fwd W0");
    chk("fwd W0 literal", 32'(fout), 32'h00);

    // Backward with bin=FF on W=0 and fin=~PAT loads every row with PAT.
    run_pass(1'b0, 1'b1, ~PAT, 8'hFF, 1'b0, "bwd preload");
    chk("preload blame", 32'(bout), 32'(PAT));
    check_w("preload W");
    run_pass(1'b1, 1'b0, PAT, 8'h00, 1'b0, "fwd W=fin");
    chk("fwd W=fin literal", 32'(fout), 32'hFF);
    @(negedge clk);
    rd_row = 3'd5;
    #1;
    chk("control_out row5", 32'(control_out), 32'(PAT));

    // No wrong neurons: no updates and no blame.
    run_pass(1'b0, 1'b1, 9'h0A5, 8'h00, 1'b0, "bwd bin0");
    chk("bwd bin0 literal", 32'(bout), 32'd0);
    check_w("bwd bin0 W");

    // Mixed rows and inputs to exercise varied majority counts.
    run_pass(1'b0, 1'b1, 9'h0F3, 8'h5A, 1'b0, "bwd mix1");
    run_pass(1'b0, 1'b1, 9'h13C, 8'hC3, 1'b0, "bwd mix2");
    check_w("mix W");
    run_pass(1'b1, 1'b0, 9'h0F3, 8'h00, 1'b0, "fwd mix1");
    run_pass(1'b1, 1'b0, 9'h1FF, 8'h00, 1'b0, "fwd mix2");
    run_pass(1'b1, 1'b0, PAT, 8'h00, 1'b0, "fwd mix3");

    // Both starts high: forward only; a start pulse while busy is ignored.
    run_pass(1'b1, 1'b1, 9'h155, 8'hFF, 1'b1, "both high");
    check_w("both high W");
    repeat (2) @(negedge clk);
    chk("no extra pass", 32'(busy), 32'd0);

    // All-agree backward: every weight flips to 1 and every input is blamed.
    do_reset(2);
    run_pass(1'b0, 1'b1, 9'h000, 8'hFF, 1'b0, "bwd all");
    chk("bwd all blame", 32'(bout), 32'h1FF);
    check_w("bwd all W");
    rd_row = 3'd7;
    #1;
    chk("bwd all row7", 32'(control_out), 32'h1FF);

    // Reset during cycle 2 of a backward pass.
    @(negedge clk);
    fin = '0;
    bin = 8'hFF;
    bk_prop = 1'b1;
    @(negedge clk);
    bk_prop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort lfsr", 32'(dut.lfsr_q), 32'(SEED_V));
    chk("abort bout", 32'(bout), 32'd0);
    check_w("abort W");
    rst = 1'b0;
    osc_hold = 1'b1;
    flag = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (dut.lfsr_q === 16'h0000 || done !== 1'b0) flag = 1'b0;
    end
    chk("lfsr nonzero no done", 32'(flag), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
